// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   F3_*        : RISC-V funct3 width/sign codes used by loads and stores
//   lsu_state_t : load/store unit sequencer states
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        DONE,
        ERR
    } lsu_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension.
//   word   : full 32-bit memory word (little-endian, lane k = word[8k+7:8k])
//   offset : byte offset addr[1:0] within the word
//   funct3 : load width/sign code
//   result : extended load value
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        case (offset)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];

        result = word;
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'd0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'd0, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the multicycle core and a word-write memory.
//   clk, reset              : clock, asynchronous active-high reset
//   start/isStore/funct3/addr/storeData : request (sampled in IDLE only)
//   busy, done              : not-idle flag, one-cycle completion pulse
//   misaligned, outOfRange  : error flags, valid with done
//   loadData                : extended load result, held until next load
//   memAddr/memWriteData/memRead/memWrite/memData : memory interface
// Sub-word stores are performed as read-modify-write of the whole word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic        outOfRange,
    output logic [31:0] loadData,
    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memData
);

    lsu_state_t  state, next_state;

    logic        st_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] merge_q;
    logic [31:0] ld_q;
    logic        mis_q;
    logic        oor_q;

    logic        f3_ok;
    logic        align_ok;
    logic        is_mis;
    logic        is_oor;
    logic [31:0] merged;
    logic [31:0] aligned_data;

    // Legality of the incoming request, evaluated on the start cycle.
    always_comb begin
        if (isStore)
            f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);

        case (funct3)
            F3_H, F3_HU: align_ok = ~addr[0];
            F3_W:        align_ok = (addr[1:0] == 2'b00);
            default:     align_ok = 1'b1;
        endcase

        is_mis = ~f3_ok | ~align_ok;
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        is_oor = ({1'b0, addr[31:2], 2'b00} + 33'd3) >= 33'(MEM_BYTES);
    end

    // Store bytes merged into the word just read (sb/sh only).
    always_comb begin
        merged = memData;
        if (f3_q == F3_B) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = sdata_q[7:0];
                2'd1: merged[15:8]  = sdata_q[7:0];
                2'd2: merged[23:16] = sdata_q[7:0];
                2'd3: merged[31:24] = sdata_q[7:0];
                default: merged = memData;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = sdata_q[15:0];
        end else begin
            merged[15:0] = sdata_q[15:0];
        end
    end

    load_align u_align (
        .word   (memData),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .result (aligned_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        busy         = (state != IDLE);
        done         = 1'b0;
        misaligned   = 1'b0;
        outOfRange   = 1'b0;
        memAddr      = '0;
        memWriteData = '0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mis || is_oor)   next_state = ERR;
                    else if (!isStore)      next_state = RD;
                    else if (funct3 == F3_W) next_state = WR;
                    else                    next_state = RMW_RD;
                end
            end
            RD: begin
                memAddr    = {addr_q[31:2], 2'b00};
                memRead    = 1'b1;
                next_state = DONE;
            end
            RMW_RD: begin
                memAddr    = {addr_q[31:2], 2'b00};
                memRead    = 1'b1;
                next_state = WR;
            end
            WR: begin
                memAddr      = {addr_q[31:2], 2'b00};
                memWrite     = 1'b1;
                memWriteData = (f3_q == F3_W) ? sdata_q : merge_q;
                next_state   = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                misaligned = mis_q;
                outOfRange = oor_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            merge_q <= '0;
            ld_q    <= '0;
            mis_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        st_q    <= isStore;
                        f3_q    <= funct3;
                        addr_q  <= addr;
                        sdata_q <= storeData;
                        mis_q   <= is_mis;
                        oor_q   <= is_oor & ~is_mis;
                    end
                end
                RD:      ld_q    <= aligned_data;
                RMW_RD:  merge_q <= merged;
                default: ;
            endcase
        end
    end

    assign loadData = ld_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        busy, done, misaligned, outOfRange;
    logic [31:0] loadData, memAddr, memWriteData, memData;
    logic        memRead, memWrite;

    logic [31:0] mem [0:63];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    typedef struct {
        int          t;
        int          lat;
        logic [31:0] ld;
        logic        mis;
        logic        oor;
        int          nr;
        int          nw;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];

    load_store_unit #(.MEM_BYTES(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .isStore      (isStore),
        .funct3       (funct3),
        .addr         (addr),
        .storeData    (storeData),
        .busy         (busy),
        .done         (done),
        .misaligned   (misaligned),
        .outOfRange   (outOfRange),
        .loadData     (loadData),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memData      (memData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign memData = mem[memAddr[7:2]];

    always @(posedge clk) begin
        if (memWrite) mem[memAddr[7:2]] <= memWriteData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: observes the memory interface and pops the scoreboard on done.
    always @(negedge clk) begin
        if (!reset) begin
            if (!busy) begin
                check("idle_mem", {memAddr[30:0], memRead, memWrite}, 33'd0);
            end
            if (memRead && memWrite) check("rd_wr_overlap", 32'd1, 32'd0);
            if (memRead) begin
                rd_cnt++;
                if (q.size() != 0) check("rd_addr", memAddr, q[0].waddr);
            end
            if (memWrite) begin
                wr_cnt++;
                if (q.size() != 0) begin
                    check("wr_addr", memAddr, q[0].waddr);
                    check("wr_data", memWriteData, q[0].wdata);
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("latency", 32'(cyc - e.t), 32'(e.lat));
                    check("loadData", loadData, e.ld);
                    check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                    check("outOfRange", {31'd0, outOfRange}, {31'd0, e.oor});
                    check("read_cycles", 32'(rd_cnt), 32'(e.nr));
                    check("write_cycles", 32'(wr_cnt), 32'(e.nw));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int lat, input logic [31:0] ld,
                         input logic mis, input logic oor, input int nr, input int nw,
                         input logic [31:0] wd, input bit dbl);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        isStore   = st;
        funct3    = f3;
        addr      = a;
        storeData = sd;
        e.t = cyc; e.lat = lat; e.ld = ld; e.mis = mis; e.oor = oor;
        e.nr = nr; e.nw = nw; e.waddr = {a[31:2], 2'b00}; e.wdata = wd;
        q.push_back(e);
        @(negedge clk);
        if (!dbl) start = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            check("done_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[8'h84 >> 2] = 32'hDEADBEEF;
        mem[8'h88 >> 2] = 32'h11223344;
        mem[8'hFC >> 2] = 32'hCAFEF00D;
        reset = 1'b1; start = 1'b0; isStore = 1'b0; funct3 = 3'd0;
        addr = '0; storeData = '0;
        #1;
        check("reset_flags", {28'd0, busy, done, misaligned, outOfRange}, 32'd0);
        check("reset_loadData", loadData, 32'd0);
        check("reset_memAddr", memAddr, 32'd0);
        check("reset_strobes", {30'd0, memRead, memWrite}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        //    st    f3      addr        storeData     lat loadData       mis oor nr nw wdata        dbl
        issue(1'b0, 3'b000, 32'h85,  32'h0,          2, 32'hFFFFFFBE, 0, 0, 1, 0, 32'h0,        0);
        issue(1'b0, 3'b101, 32'h86,  32'h0,          2, 32'h0000DEAD, 0, 0, 1, 0, 32'h0,        0);
        issue(1'b0, 3'b001, 32'h84,  32'h0,          2, 32'hFFFFBEEF, 0, 0, 1, 0, 32'h0,        0);
        issue(1'b0, 3'b100, 32'h84,  32'h0,          2, 32'h000000EF, 0, 0, 1, 0, 32'h0,        0);
        issue(1'b1, 3'b000, 32'h87,  32'h00000012,   3, 32'h000000EF, 0, 0, 1, 1, 32'h12ADBEEF, 0);
        issue(1'b0, 3'b010, 32'h84,  32'h0,          2, 32'h12ADBEEF, 0, 0, 1, 0, 32'h0,        0);
        issue(1'b0, 3'b010, 32'h82,  32'h0,          1, 32'h12ADBEEF, 1, 0, 0, 0, 32'h0,        0);
        issue(1'b1, 3'b010, 32'h100, 32'h55555555,   1, 32'h12ADBEEF, 0, 1, 0, 0, 32'h0,        0);
        issue(1'b0, 3'b010, 32'hFC,  32'h0,          2, 32'hCAFEF00D, 0, 0, 1, 0, 32'h0,        0);
        issue(1'b1, 3'b001, 32'h8A,  32'hAAAA5566,   3, 32'hCAFEF00D, 0, 0, 1, 1, 32'h55663344, 0);
        issue(1'b0, 3'b000, 32'h8B,  32'h0,          2, 32'h00000055, 0, 0, 1, 0, 32'h0,        0);
        issue(1'b0, 3'b011, 32'h84,  32'h0,          1, 32'h00000055, 1, 0, 0, 0, 32'h0,        0);
        issue(1'b1, 3'b100, 32'h84,  32'h0,          1, 32'h00000055, 1, 0, 0, 0, 32'h0,        0);
        issue(1'b0, 3'b001, 32'h101, 32'h0,          1, 32'h00000055, 1, 0, 0, 0, 32'h0,        0);
        issue(1'b0, 3'b001, 32'h8A,  32'h0,          2, 32'h00005566, 0, 0, 1, 0, 32'h0,        1);
        check("mem_after_sb", mem[8'h84 >> 2], 32'h12ADBEEF);

        // Reset during the WR cycle of a sw to 0x88.
        @(negedge clk);
        start = 1'b1; isStore = 1'b1; funct3 = 3'b010; addr = 32'h88; storeData = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("wr_state_reached", {31'd0, memWrite}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_flags", {28'd0, busy, done, memRead, memWrite}, 32'd0);
        check("rst_mid_addr", memAddr, 32'd0);
        check("rst_mid_wdata", memWriteData, 32'd0);
        check("rst_mid_loadData", loadData, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mem_0x88_kept", mem[8'h88 >> 2], 32'h55663344);
        issue(1'b0, 3'b010, 32'h88,  32'h0,          2, 32'h55663344, 0, 0, 1, 0, 32'h0,        0);

        repeat (5) @(negedge clk);
        check("leftover_expect", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the multicycle control/datapath and the unified byte-addressed memory. It takes one load or store request per handshake, drives the memory's address, write data and read/write strobes, and returns sign- or zero-extended load data. The memory only writes full 32-bit words, so the block performs sub-word stores (sb/sh) as a read-modify-write sequence. It detects misaligned and out-of-range accesses before touching memory.

Parameters:
MEM_BYTES, 256, size of backing memory in bytes; a word-aligned access is legal only if aligned address + 3 < MEM_BYTES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces IDLE immediately
start  input  1  request strobe; sampled only in IDLE
isStore  input  1  1 = store, 0 = load
funct3  input  3  RISC-V width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr  input  32  byte address of access
storeData  input  32  store source, rs2 value; low bits used for sb/sh
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
misaligned  output  1  valid with done; access was misaligned or had an illegal funct3
outOfRange  output  1  valid with done; aligned word exceeds MEM_BYTES
loadData  output  32  extended load result; held until next successful load
memAddr  output  32  word-aligned address {addr[31:2],2'b00}; 0 when idle
memWriteData  output  32  word to write; 0 outside WR
memRead  output  1  memory read enable
memWrite  output  1  memory write enable
memData  input  32  combinational memory read data

Behaviour:
- Reset values: state=IDLE, every output 0, internal latches 0. An asynchronous reset mid-operation cancels the access. If it lands in WR, memWrite drops before the edge, so no write occurs.
- IDLE: on start, latch isStore, funct3, addr and storeData. start is ignored while busy.
- Legality check in IDLE, on the start cycle:
  - h/hu/sh need addr[0]=0; w/sw need addr[1:0]=0.
  - Illegal funct3 (load: 011,110,111; store: anything but 000/001/010) counts as misaligned.
  - Misaligned has priority over out-of-range.
  - An illegal access goes to ERR; no memRead or memWrite is ever asserted for it.
- States and transitions:
  - IDLE: load -> RD; sw -> WR; sb/sh -> RMW_RD; illegal -> ERR.
  - RD: memRead=1. At the edge, register the extracted and extended memData into loadData. -> DONE.
  - RMW_RD: memRead=1. At the edge, register memData with the store bytes merged in. -> WR.
    - sb replaces lane addr[1:0] with storeData[7:0].
    - sh replaces lanes {addr[1],0} and {addr[1],1} with storeData[15:0].
  - WR: memWrite=1; memWriteData = merged word (sb/sh) or storeData (sw). -> DONE.
  - DONE: done=1 for one cycle. -> IDLE.
  - ERR: done=1, with misaligned or outOfRange set, for one cycle. -> IDLE.
- Latency, with start at cycle T:
  - load: done in T+2
  - sw: done in T+2
  - sb/sh: done in T+3
  - illegal: done in T+1
- Load extraction from lane addr[1:0]:
  - lb: sign-extend bit 7; lbu: zero-extend.
  - lh uses bytes at {addr[1],1}:{addr[1],0}, sign-extended from bit 15; lhu zero-extends.
  - lw: full word.
- Little-endian: byte lane k = memData[8k+7:8k].
- memAddr holds the latched aligned address throughout RD/RMW_RD/WR. memRead and memWrite are never high together.
- loadData is unchanged by stores and errors.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum: IDLE, RD, RMW_RD, WR, DONE, ERR
- Sub-module load_align: combinational lane select and sign/zero extension (word, offset[1:0], funct3 -> 32-bit result). The store merge stays inline.

Test Plan:
- Memory word 0x84 = 0xDEADBEEF. lb addr 0x85 -> loadData=0xFFFFFFBE, done at T+2, memAddr=0x84 with memRead high in T+1 only.
- Same word. lhu addr 0x86 -> loadData=0x0000DEAD. lh addr 0x84 -> 0xFFFFBEEF.
- sb addr 0x87, storeData=0x00000012 -> exactly one memWrite cycle (T+2) at 0x84 with memWriteData=0x12ADBEEF, done at T+3. A follow-up lw 0x84 reads 0x12ADBEEF.
- Illegal accesses:
  - lw 0x82 -> done and misaligned at T+1, memRead/memWrite never high, loadData unchanged.
  - sw addr 0x100 with MEM_BYTES=256 -> outOfRange, no write.
  - lw 0xFC is legal.
- Reset asserted during WR of a sw to 0x88 -> outputs 0 within the same cycle, word at 0x88 unchanged, next start accepted normally.
- start pulsed again at T+1 during a busy load -> ignored; exactly one done.
